// File: rtl/gcd_pkg.sv
// Shared types and defaults for the round-robin arbitrated GCD engine.
package gcd_pkg;

    localparam int GCD_WIDTH   = 8;
    localparam int GCD_NUM_REQ = 4;
    localparam int LAT_W       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gcd_core.sv
// Subtractive GCD datapath: loads x/y, then subtracts one step per cycle until an operand is zero.
// Runs freely after load and holds once zero is reached, so result stays stable for the controller.
module gcd_core
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             zero,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_d;

    assign zero   = (x_q == '0) || (y_q == '0);
    assign result = x_q | y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load) begin
            x_d = a;
            y_d = b;
        end else if (!zero) begin
            if (x_q >= y_q) begin
                x_d = x_q - y_q;
            end else begin
                y_d = y_q - x_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD engine; ack 1 cycle after grant, done after (steps+1) cycles.
// No backpressure: req is sampled only in IDLE. Define GCD_ARB_CYCLE_CNT_EN to add the lat_cnt output.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int NUM_REQ = GCD_NUM_REQ,
    parameter int WIDTH   = GCD_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       done,
    output logic [WIDTH-1:0]         gcd_out,
    output logic                     busy
`ifdef GCD_ARB_CYCLE_CNT_EN
    ,
    output logic [LAT_W-1:0]         lat_cnt
`endif
);

    localparam int IDXW = $clog2(NUM_REQ);

    state_t             state_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] done_q;
    logic [WIDTH-1:0]   gcd_q;
    logic               busy_q;
    logic [IDXW-1:0]    last_q;
    logic [IDXW-1:0]    owner_q;

    logic [IDXW-1:0]    cand;
    logic [IDXW-1:0]    win_idx;
    logic               win_found;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] owner_oh;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic               load;
    logic               core_zero;
    logic [WIDTH-1:0]   core_result;

    assign ack     = ack_q;
    assign done    = done_q;
    assign gcd_out = gcd_q;
    assign busy    = busy_q;

    // Search starts one past the last completed owner and wraps once around.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDXW'((int'(last_q) + k) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_oh   = '0;
        owner_oh = '0;
        a_sel    = '0;
        b_sel    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_oh[i]   = (win_idx == IDXW'(i));
            owner_oh[i] = (owner_q == IDXW'(i));
            if (win_idx == IDXW'(i)) begin
                a_sel = a_in[i*WIDTH +: WIDTH];
                b_sel = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load = (state_q == IDLE) && (|req);

    gcd_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .a      (a_sel),
        .b      (b_sel),
        .zero   (core_zero),
        .result (core_result)
    );

`ifdef GCD_ARB_CYCLE_CNT_EN
    logic [LAT_W-1:0] cyc_q;
    logic [LAT_W-1:0] lat_q;
    assign lat_cnt = lat_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= '0;
            done_q  <= '0;
            gcd_q   <= '0;
            busy_q  <= 1'b0;
            last_q  <= IDXW'(NUM_REQ - 1);
            owner_q <= '0;
`ifdef GCD_ARB_CYCLE_CNT_EN
            cyc_q   <= '0;
            lat_q   <= '0;
`endif
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        ack_q   <= win_oh;
                        busy_q  <= 1'b1;
                        owner_q <= win_idx;
                        state_q <= BUSY;
`ifdef GCD_ARB_CYCLE_CNT_EN
                        cyc_q   <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (core_zero) begin
                        done_q  <= owner_oh;
                        gcd_q   <= core_result;
                        state_q <= DONE;
`ifdef GCD_ARB_CYCLE_CNT_EN
                        lat_q   <= (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
`endif
                    end
`ifdef GCD_ARB_CYCLE_CNT_EN
                    else if (cyc_q != '1) begin
                        cyc_q <= cyc_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    gcd_q   <= '0;
                    busy_q  <= 1'b0;
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Randomized scoreboard bench for gcd_arbiter with a transaction-level round-robin/GCD model.
module tb_gcd_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   ack;
    logic [N-1:0]   done;
    logic [W-1:0]   gcd_out;
    logic           busy;
`ifdef GCD_ARB_CYCLE_CNT_EN
    logic [15:0]    lat_cnt;
`endif

    always #5 clk = ~clk;

    gcd_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .ack     (ack),
        .done    (done),
        .gcd_out (gcd_out),
        .busy    (busy)
`ifdef GCD_ARB_CYCLE_CNT_EN
        ,
        .lat_cnt (lat_cnt)
`endif
    );

    typedef struct {
        int idx;
        int g;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   model_last = N - 1;
    int   op_a[N];
    int   op_b[N];
    int   cyc        = 0;
    int   ack_cyc    = 0;
    int   done_cyc   = 0;
    bit   req_at_done = 1'b0;
    bit   mon_en     = 1'b0;

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // ack-to-done cycles: one per subtraction, plus one to report the result
    function automatic int ref_lat(input int a, input int b);
        int s = 0;
        while (a != 0 && b != 0) begin
            if (a >= b) a = a - b;
            else        b = b - a;
            s++;
        end
        return s + 1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int rand_op();
        if ($urandom_range(0, 7) == 0) return 0;
        return int'($urandom_range(1, 255));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            a_in[i*W +: W] = W'(op_a[i]);
            b_in[i*W +: W] = W'(op_b[i]);
        end
    endtask

    task automatic push_exp(input int i);
        exp_t e;
        e.idx = i;
        e.g   = ref_gcd(op_a[i], op_b[i]);
        e.lat = ref_lat(op_a[i], op_b[i]);
        exp_q.push_back(e);
        model_last = i;
    endtask

    task automatic wait_ack(output int who);
        int t = 0;
        who = -1;
        while (who < 0 && t < 2000) begin
            @(posedge clk);
            #2;
            if (ack != '0) who = idx_of(ack);
            t++;
        end
        if (who < 0) fail_now("ack_timeout");
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (t >= 3000) begin
            fail_now("idle_timeout");
            exp_q.delete();
        end
    endtask

    // Requests held until acked; the acked requester's operands are then scrambled.
    task automatic run_batch(input logic [N-1:0] mask, input bit rnd);
        int who;
        int start;
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                op_a[i] = rand_op();
                op_b[i] = rand_op();
            end
        end
        drive_ops();
        start = model_last;
        for (int k = 1; k <= N; k++) begin
            if (mask[(start + k) % N]) push_exp((start + k) % N);
        end
        req = mask;
        while (req != '0) begin
            wait_ack(who);
            if (who < 0) begin
                req = '0;
            end else begin
                req[who] = 1'b0;
                a_in[who*W +: W] = W'($urandom);
                b_in[who*W +: W] = W'($urandom);
            end
        end
        wait_idle();
    endtask

    task automatic single(input int i, input int a, input int b);
        op_a[i] = a;
        op_b[i] = b;
        run_batch(N'(1) << i, 1'b0);
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (rst_n && mon_en) begin
            if (ack != '0) begin
                check("ack_onehot", $countones(ack), 1);
                check("busy_at_ack", int'(busy), 1);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    check("ack_idx", idx_of(ack), exp_q[0].idx);
                end
                if (req_at_done) check("ack_gap", cyc - done_cyc, 2);
                req_at_done = 1'b0;
                ack_cyc = cyc;
            end
            if (done != '0) begin
                check("done_onehot", $countones(done), 1);
                check("busy_at_done", int'(busy), 1);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    check("done_idx", idx_of(done), e.idx);
                    check("gcd_out", int'(gcd_out), e.g);
                    check("done_latency", cyc - ack_cyc, e.lat);
`ifdef GCD_ARB_CYCLE_CNT_EN
                    check("lat_cnt", int'(lat_cnt), e.lat);
`endif
                end
                done_cyc    = cyc;
                req_at_done = (req != '0);
            end
        end
    end

    initial begin
        #1_000_000;
        fail_now("watchdog");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int who;
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ack", int'(ack), 0);
        check("rst_done", int'(done), 0);
        check("rst_gcd", int'(gcd_out), 0);
        check("rst_busy", int'(busy), 0);
`ifdef GCD_ARB_CYCLE_CNT_EN
        check("rst_lat", int'(lat_cnt), 0);
`endif
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #2;
        check("idle_busy", int'(busy), 0);

        // All four held: grants 0,1,2,3,0 from the reset pointer
        for (int i = 0; i < N; i++) begin
            op_a[i] = 56;
            op_b[i] = 49;
        end
        drive_ops();
        for (int k = 1; k <= 5; k++) push_exp((N - 1 + k) % N);
        req = '1;
        for (int g = 0; g < 5; g++) wait_ack(who);
        req = '0;
        wait_idle();

        single(0, 20, 15);
        single(0, 0, 16);
        single(0, 20, 0);
        single(0, 0, 0);

        // Operand change and late request during BUSY
        op_a[0] = 20;
        op_b[0] = 15;
        op_a[2] = 36;
        op_b[2] = 24;
        drive_ops();
        push_exp(0);
        req = 4'b0001;
        wait_ack(who);
        req = 4'b0100;
        a_in[0 +: W] = 8'd77;
        push_exp(2);
        wait_ack(who);
        req = '0;
        wait_idle();

        // Reset while requester 3 is mid-computation
        op_a[3] = 255;
        op_b[3] = 1;
        drive_ops();
        push_exp(3);
        req = 4'b1000;
        wait_ack(who);
        req = '0;
        repeat (3) @(posedge clk);
        #2;
        exp_q.delete();
        req_at_done = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_last = N - 1;
        check("midrst_ack", int'(ack), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_gcd", int'(gcd_out), 0);
        check("midrst_busy", int'(busy), 0);
        repeat (300) @(posedge clk);
        #2;
        run_batch(4'b0010, 1'b1);

        for (int t = 0; t < 25; t++) begin
            run_batch(N'($urandom_range(1, (1 << N) - 1)), 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #2;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The module SHALL have parameter WIDTH, default 8, giving the operand and result width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The module SHALL have port req, input, NUM_REQ bits: level request, one bit per requester.
REQ-006 The module SHALL have port a_in, input, NUM_REQ*WIDTH bits: packed operand A; requester i uses slice [i*WIDTH +: WIDTH].
REQ-007 The module SHALL have port b_in, input, NUM_REQ*WIDTH bits: packed operand B, sliced as a_in.
REQ-008 The module SHALL have port ack, output, NUM_REQ bits: one-cycle pulse when requester i's operands are captured.
REQ-009 The module SHALL have port done, output, NUM_REQ bits: one-cycle pulse when requester i's result is valid.
REQ-010 The module SHALL have port gcd_out, output, WIDTH bits: result, valid only while any done bit is high.
REQ-011 The module SHALL have port busy, output, 1 bit: high while the shared engine is allocated.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE; all outputs SHALL be registered.
REQ-013 In IDLE with req nonzero, the winner SHALL be chosen round-robin, starting the search at the index after the last granted requester.
REQ-014 On that edge the module SHALL load the winner's a/b into the engine, set ack[winner] and busy, and enter BUSY.
REQ-015 In IDLE with req zero, the module SHALL stay in IDLE.
REQ-016 In BUSY, each edge SHALL perform one step: if x>=y then x<=x-y, else y<=y-x.
REQ-017 In BUSY, when x==0 or y==0, the next edge SHALL set done[owner], set gcd_out=x|y and enter DONE without stepping.
REQ-018 Results SHALL satisfy gcd(0,b)=b, gcd(a,0)=a and gcd(0,0)=0.
REQ-019 DONE SHALL last exactly one cycle, clear done and busy, update the last-grant pointer to the owner, and return to IDLE.
REQ-020 A new grant SHALL occur no earlier than the edge leaving DONE, so there is at least one idle cycle between done and the next ack.
REQ-021 Requests arriving or dropping while not in IDLE SHALL be ignored until IDLE; a requester still holding req after its done SHALL be treated as a new request.
REQ-022 Operand inputs SHALL be sampled only on the grant edge; later changes SHALL NOT affect the result.
REQ-023 At most one ack bit and at most one done bit SHALL be high in any cycle.

Reset
REQ-024 When rst_n is low at an edge, the module SHALL force IDLE, ack=0, done=0, gcd_out=0, busy=0 and last-grant pointer=NUM_REQ-1, so requester 0 wins first.
REQ-025 Reset mid-operation SHALL abandon the operation and SHALL produce no done pulse for it.

Configuration
REQ-026 With GCD_ARB_CYCLE_CNT_EN defined, the module SHALL add output lat_cnt (16 bits), holding the number of cycles from ack to done of the last completed operation, saturating at 16'hFFFF, reset to 0, updated together with done.
REQ-027 With GCD_ARB_CYCLE_CNT_EN undefined, lat_cnt and its counter SHALL be absent.

Structure
REQ-028 A shared package gcd_pkg SHALL hold the FSM state typedef (IDLE/BUSY/DONE) and the default WIDTH and NUM_REQ constants.
REQ-029 The subtract-and-compare datapath SHALL be a sub-module gcd_core (ports clk, rst_n, load, a, b, zero, result).
REQ-030 Arbitration and the FSM SHALL live in gcd_arbiter.

Verification
REQ-031 Reset, then req=0001 with a0=20, b0=15 -> ack[0] one cycle later; done[0] with gcd_out=5 exactly 5 cycles after ack.
REQ-032 req=0001 with a0=0, b0=16, then separately req=0001 with a0=20, b0=0 -> done 1 cycle after ack with gcd_out=16, then gcd_out=20; a=b=0 -> 0.
REQ-033 req=1111 held, each requester given a=56, b=49 -> grants in order 0,1,2,3,0; each done carries gcd_out=7 and the matching done bit.
REQ-034 During BUSY for requester 0, change a0 and raise req[2] -> result unaffected; requester 2 is acked only after DONE plus one cycle.
REQ-035 Pull rst_n low for one edge mid-BUSY -> all outputs 0 next cycle, no done pulse; next req=0010 -> requester 1 acked.
REQ-036 With GCD_ARB_CYCLE_CNT_EN defined and a=20, b=15 -> lat_cnt=5 alongside done.
